// File: rtl/uart_pkg.sv
// Shared definitions for the APB-side UART register file.
// Latency: n/a (constants and one helper function only).
// Backpressure: n/a.
//
// Holds the register byte offsets, the CTRL/STATUS bit positions and the
// receive-threshold helper used by the top level.
package uart_pkg;

  // Register byte offsets; only pAddr[7:0] is decoded.
  localparam logic [7:0] UART_TXDATA_ADDR  = 8'h00;
  localparam logic [7:0] UART_RXDATA_ADDR  = 8'h01;
  localparam logic [7:0] UART_BAUDDIV_ADDR = 8'h02;
  localparam logic [7:0] UART_CTRL_ADDR    = 8'h03;
  localparam logic [7:0] UART_STATUS_ADDR  = 8'h04;
  localparam logic [7:0] UART_LEVEL_ADDR   = 8'h05;

  // CTRL bit positions.
  localparam int CTRL_TXEN     = 0;
  localparam int CTRL_RXEN     = 1;
  localparam int CTRL_RXINTEN  = 2;
  localparam int CTRL_TXINTEN  = 3;
  localparam int CTRL_TXFLUSH  = 4;
  localparam int CTRL_RXFLUSH  = 5;
  localparam int CTRL_THR_LSB  = 8;

  // STATUS bit positions.
  localparam int STAT_RXNE     = 0;
  localparam int STAT_RXFULL   = 1;
  localparam int STAT_TXEMPTY  = 2;
  localparam int STAT_TXFULL   = 3;
  localparam int STAT_RXOVR    = 4;
  localparam int STAT_TXOVF    = 5;
  localparam int STAT_RXTHR    = 6;

  // A threshold of 0 behaves like 1 so the RX interrupt never fires on an
  // empty FIFO.
  function automatic logic [7:0] thresh_eff(input logic [7:0] thr);
    return (thr == 8'd0) ? 8'd1 : thr;
  endfunction

endpackage

// File: rtl/uart_apb_regfile_fifo_fifo.sv
// Generic synchronous FIFO with first-word fall-through output.
// Latency: push visible on dout_o the cycle after the push edge; pop edge advances head.
// Backpressure: push into a full FIFO is dropped unless a pop happens in the same cycle.
//
// Module uart_sync_fifo, parameters WIDTH, DEPTH (power of 2, >= 2).
// Ports: pClk, pReset (async active-low), push_i/din_i, pop_i, flush_i,
//        dout_o (head, 0 when empty), full_o, empty_o, count_o.
// flush_i wins over any same-cycle push or pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       pClk,
  input  logic                       pReset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign count_o = count_q;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is forced to 0 when empty so stale storage never leaks out.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observable through a non-empty head.
  always_ff @(posedge pClk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_apb_regfile_fifo.sv
// APB register file for the UART with TX/RX FIFOs, baud divisor, control, status, level and IRQ.
// Latency: zero-wait-state APB; reads combinational, writes at the access edge; Irq registered (+1 cycle).
// Backpressure: TX drained by TxValid/TxReady; full-FIFO pushes drop and set sticky overflow/overrun.
//
// Ports: APB slave (pClk, pReset async active-low, pSel, pEnable, pWrite,
//        pAddr, pWdata, pReadData), TX engine (TxData, TxValid, TxReady),
//        RX engine (RxDone, RxData), BaudDiv, TxEn, RxEn, Irq.
// Optional macro UART_RX_THRESH_EN adds CTRL[15:8] RxThresh and STATUS[6];
// the RX interrupt then requires RX count >= max(RxThresh, 1).
module uart_apb_regfile_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int DIV_W    = 16
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              pSel,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [31:0]       pAddr,
  input  logic [31:0]       pWdata,
  output logic [31:0]       pReadData,
  output logic [DATA_W-1:0] TxData,
  output logic              TxValid,
  input  logic              TxReady,
  input  logic              RxDone,
  input  logic [DATA_W-1:0] RxData,
  output logic [DIV_W-1:0]  BaudDiv,
  output logic              TxEn,
  output logic              RxEn,
  output logic              Irq
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic [7:0]        addr;
  logic              access, wr_en, rd_en;
  logic              wr_tx, wr_baud, wr_ctrl, wr_stat, rd_rx;

  logic [3:0]        ctrl_q, ctrl_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic              rx_ovr_q, rx_ovr_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              irq_q, irq_d;
`ifdef UART_RX_THRESH_EN
  logic [7:0]        thresh_q, thresh_d;
  logic              rx_thr_hit;
`endif

  logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic [DATA_W-1:0] tx_dout;
  logic [TX_CW-1:0]  tx_count;
  logic              rx_push, rx_flush, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_dout;
  logic [RX_CW-1:0]  rx_count;
  logic              rx_term;
  logic [31:0]       rdata;
  logic              unused_ok;

  assign addr    = pAddr[7:0];
  assign access  = pSel && pEnable;
  assign wr_en   = access && pWrite;
  assign rd_en   = access && !pWrite;
  assign wr_tx   = wr_en && (addr == UART_TXDATA_ADDR);
  assign wr_baud = wr_en && (addr == UART_BAUDDIV_ADDR);
  assign wr_ctrl = wr_en && (addr == UART_CTRL_ADDR);
  assign wr_stat = wr_en && (addr == UART_STATUS_ADDR);
  assign rd_rx   = rd_en && (addr == UART_RXDATA_ADDR);

  // High address bits and unused write-data bits are intentionally ignored.
  assign unused_ok = ^{pAddr[31:8], pWdata};

  assign TxValid  = ctrl_q[CTRL_TXEN] && !tx_empty;
  assign tx_push  = wr_tx;
  assign tx_pop   = TxValid && TxReady;
  assign tx_flush = wr_ctrl && pWdata[CTRL_TXFLUSH];
  assign rx_push  = RxDone && ctrl_q[CTRL_RXEN];
  assign rx_flush = wr_ctrl && pWdata[CTRL_RXFLUSH];

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .pClk    (pClk),
    .pReset  (pReset),
    .push_i  (tx_push),
    .din_i   (pWdata[DATA_W-1:0]),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .dout_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .pClk    (pClk),
    .pReset  (pReset),
    .push_i  (rx_push),
    .din_i   (RxData),
    .pop_i   (rd_rx),
    .flush_i (rx_flush),
    .dout_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

`ifdef UART_RX_THRESH_EN
  assign rx_thr_hit = (16'(rx_count) >= {8'h00, thresh_eff(thresh_q)});
  assign rx_term    = ctrl_q[CTRL_RXINTEN] && rx_thr_hit;
`else
  assign rx_term    = ctrl_q[CTRL_RXINTEN] && !rx_empty;
`endif

  always_comb begin
    ctrl_d   = ctrl_q;
    baud_d   = baud_q;
    rx_ovr_d = rx_ovr_q;
    tx_ovf_d = tx_ovf_q;
`ifdef UART_RX_THRESH_EN
    thresh_d = thresh_q;
`endif
    if (wr_ctrl) begin
      ctrl_d = pWdata[3:0];
`ifdef UART_RX_THRESH_EN
      thresh_d = pWdata[CTRL_THR_LSB +: 8];
`endif
    end
    if (wr_baud) baud_d = pWdata[DIV_W-1:0];
    // W1C first so a same-cycle set overrides the clear.
    if (wr_stat && pWdata[STAT_RXOVR]) rx_ovr_d = 1'b0;
    if (wr_stat && pWdata[STAT_TXOVF]) tx_ovf_d = 1'b0;
    // A drop only happens when nothing frees a slot in the same cycle.
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_push && rx_full && !rd_rx)  rx_ovr_d = 1'b1;
    irq_d = rx_term || (ctrl_q[CTRL_TXINTEN] && tx_empty) || rx_ovr_q || tx_ovf_q;
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      ctrl_q   <= '0;
      baud_q   <= '0;
      rx_ovr_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      irq_q    <= 1'b0;
`ifdef UART_RX_THRESH_EN
      thresh_q <= '0;
`endif
    end else begin
      ctrl_q   <= ctrl_d;
      baud_q   <= baud_d;
      rx_ovr_q <= rx_ovr_d;
      tx_ovf_q <= tx_ovf_d;
      irq_q    <= irq_d;
`ifdef UART_RX_THRESH_EN
      thresh_q <= thresh_d;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      UART_RXDATA_ADDR:  rdata = 32'(rx_dout);
      UART_BAUDDIV_ADDR: rdata = 32'(baud_q);
      UART_CTRL_ADDR: begin
        rdata[3:0] = ctrl_q;
`ifdef UART_RX_THRESH_EN
        rdata[CTRL_THR_LSB +: 8] = thresh_q;
`endif
      end
      UART_STATUS_ADDR: begin
        rdata[STAT_RXNE]    = !rx_empty;
        rdata[STAT_RXFULL]  = rx_full;
        rdata[STAT_TXEMPTY] = tx_empty;
        rdata[STAT_TXFULL]  = tx_full;
        rdata[STAT_RXOVR]   = rx_ovr_q;
        rdata[STAT_TXOVF]   = tx_ovf_q;
`ifdef UART_RX_THRESH_EN
        rdata[STAT_RXTHR]   = rx_thr_hit;
`endif
      end
      UART_LEVEL_ADDR: begin
        rdata[7:0]  = 8'(tx_count);
        rdata[15:8] = 8'(rx_count);
      end
      default: rdata = '0;
    endcase
  end

  // Drive read data only during a read transfer so the bus idles at 0.
  assign pReadData = (pSel && !pWrite) ? rdata : '0;
  assign TxData    = tx_dout;
  assign BaudDiv   = baud_q;
  assign TxEn      = ctrl_q[CTRL_TXEN];
  assign RxEn      = ctrl_q[CTRL_RXEN];
  assign Irq       = irq_q;

endmodule

// File: tb/tb_uart_apb_regfile_fifo.sv
// Scoreboard bench for uart_apb_regfile_fifo: stimulus queues expected values,
// a negedge monitor compares them against the selected DUT output.
module tb_uart_apb_regfile_fifo;

  logic        pClk = 1'b0;
  logic        pReset = 1'b0;
  logic        pSel = 1'b0, pEnable = 1'b0, pWrite = 1'b0;
  logic [31:0] pAddr = '0, pWdata = '0;
  logic [31:0] pReadData;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady = 1'b0;
  logic        RxDone = 1'b0;
  logic [7:0]  RxData = '0;
  logic [15:0] BaudDiv;
  logic        TxEn, RxEn, Irq;

  uart_apb_regfile_fifo #(.DATA_W(8), .TX_DEPTH(8), .RX_DEPTH(8), .DIV_W(16)) dut (
    .pClk(pClk), .pReset(pReset), .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite),
    .pAddr(pAddr), .pWdata(pWdata), .pReadData(pReadData),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
    .RxDone(RxDone), .RxData(RxData), .BaudDiv(BaudDiv),
    .TxEn(TxEn), .RxEn(RxEn), .Irq(Irq)
  );

  always #5 pClk = ~pClk;

  typedef enum int {SEL_RDATA, SEL_TXDATA, SEL_TXVALID, SEL_IRQ, SEL_BAUD, SEL_TXEN, SEL_RXEN} sel_t;
  typedef struct { string name; logic [31:0] exp; } exp_t;

  exp_t  exp_q[$];
  sel_t  smp_sel = SEL_RDATA;
  logic  smp_vld = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;

  // Monitor: whenever the bench flags a presented output, pop and compare.
  always @(negedge pClk) begin
    if (smp_vld) begin
      logic [31:0] act;
      exp_t e;
      case (smp_sel)
        SEL_RDATA:   act = pReadData;
        SEL_TXDATA:  act = {24'h0, TxData};
        SEL_TXVALID: act = {31'h0, TxValid};
        SEL_IRQ:     act = {31'h0, Irq};
        SEL_BAUD:    act = {16'h0, BaudDiv};
        SEL_TXEN:    act = {31'h0, TxEn};
        default:     act = {31'h0, RxEn};
      endcase
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got %h with no expected entry", act);
      end else begin
        e = exp_q.pop_front();
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_out(input sel_t sel, input logic [31:0] e, input string nm);
    exp_t ent;
    ent.name = nm;
    ent.exp  = e;
    exp_q.push_back(ent);
    smp_sel = sel;
    smp_vld = 1'b1;
    @(negedge pClk);
    #1 smp_vld = 1'b0;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input bit txr = 1'b0);
    @(posedge pClk); #1;
    pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddr = {24'h0, a}; pWdata = d;
    @(posedge pClk); #1;
    pEnable = 1'b1; TxReady = txr;
    @(posedge pClk); #1;
    pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0; TxReady = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [31:0] e, input string nm,
                          input bit rx_also = 1'b0, input logic [7:0] rxd = 8'h00);
    @(posedge pClk); #1;
    pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddr = {24'h0, a};
    @(posedge pClk); #1;
    pEnable = 1'b1;
    if (rx_also) begin RxDone = 1'b1; RxData = rxd; end
    expect_out(SEL_RDATA, e, nm);
    @(posedge pClk); #1;
    pSel = 1'b0; pEnable = 1'b0; RxDone = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(posedge pClk); #1;
    RxDone = 1'b1; RxData = d;
    @(posedge pClk); #1;
    RxDone = 1'b0;
  endtask

  task automatic tx_pulse();
    @(posedge pClk); #1 TxReady = 1'b1;
    @(posedge pClk); #1 TxReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    expect_out(SEL_TXVALID, 0, "rst_txvalid");
    expect_out(SEL_IRQ, 0, "rst_irq");
    expect_out(SEL_TXDATA, 0, "rst_txdata");
    expect_out(SEL_BAUD, 0, "rst_baud");
    expect_out(SEL_RDATA, 0, "rst_rdata_idle");
    repeat (2) @(posedge pClk);
    #1 pReset = 1'b1;
    apb_read(8'h00, 32'h0, "rd_txdata");
    apb_read(8'h01, 32'h0, "rd_rxdata_rst");
    apb_read(8'h02, 32'h0, "rd_baud_rst");
    apb_read(8'h03, 32'h0, "rd_ctrl_rst");
    apb_read(8'h04, 32'h4, "rd_status_rst");
    apb_read(8'h05, 32'h0, "rd_level_rst");
    apb_read(8'h10, 32'h0, "rd_undecoded");
    apb_write(8'h02, 32'h0000_1234);
    apb_read(8'h02, 32'h1234, "rd_baud");
    expect_out(SEL_BAUD, 32'h1234, "baud_out");
    apb_write(8'h06, 32'hFFFF_FFFF);
    apb_read(8'h06, 32'h0, "rd_undecoded_after_wr");

    // 2: TX path with FWFT head
    apb_write(8'h03, 32'h01);
    expect_out(SEL_TXEN, 1, "txen_out");
    expect_out(SEL_RXEN, 0, "rxen_out");
    apb_write(8'h00, 32'hA5);
    apb_write(8'h00, 32'h3C);
    expect_out(SEL_TXVALID, 1, "tx_valid");
    expect_out(SEL_TXDATA, 32'hA5, "tx_head_a5");
    apb_read(8'h05, 32'h0002, "tx_level2");
    apb_read(8'h04, 32'h0, "status_tx2");
    expect_out(SEL_TXDATA, 32'hA5, "tx_hold_a5");
    tx_pulse();
    expect_out(SEL_TXDATA, 32'h3C, "tx_head_3c");
    tx_pulse();
    expect_out(SEL_TXVALID, 0, "tx_valid_empty");
    apb_read(8'h04, 32'h4, "status_tx_empty");

    // 3: TX full / overflow / simultaneous push+pop / flush
    apb_write(8'h03, 32'h00);
    for (int i = 0; i < 9; i++) apb_write(8'h00, 32'(i + 1));
    apb_read(8'h05, 32'h0008, "tx_level_full");
    apb_read(8'h04, 32'h28, "status_txfull_ovf");
    expect_out(SEL_IRQ, 1, "irq_ovf");
    apb_write(8'h04, 32'h20);
    apb_read(8'h04, 32'h08, "status_ovf_cleared");
    expect_out(SEL_IRQ, 0, "irq_ovf_cleared");
    apb_write(8'h03, 32'h01);
    expect_out(SEL_TXDATA, 32'h01, "tx_head_full");
    apb_write(8'h00, 32'h99, 1'b1);
    apb_read(8'h05, 32'h0008, "tx_level_pushpop");
    apb_read(8'h04, 32'h08, "status_pushpop_no_ovf");
    expect_out(SEL_TXDATA, 32'h02, "tx_head_after_pop");
    apb_write(8'h03, 32'h11);
    apb_read(8'h05, 32'h0, "tx_level_flushed");
    apb_read(8'h04, 32'h4, "status_tx_flushed");
    expect_out(SEL_TXVALID, 0, "tx_valid_flushed");
    apb_read(8'h03, 32'h01, "ctrl_flush_reads0");

    // 4: RX push, interrupt latency, read pop
    apb_write(8'h03, 32'h06);
    rx_pulse(8'h55);
    expect_out(SEL_IRQ, 0, "irq_not_yet");
    @(posedge pClk);
    expect_out(SEL_IRQ, 1, "irq_rx");
    apb_read(8'h01, 32'h55, "rx_read_55");
    apb_read(8'h04, 32'h04, "status_rx_empty");
    expect_out(SEL_IRQ, 0, "irq_rx_drop");
    apb_read(8'h01, 32'h0, "rx_read_empty");
    apb_read(8'h05, 32'h0, "rx_level0");

    // 5: RX full, simultaneous push+read, overrun
    apb_write(8'h03, 32'h02);
    for (int i = 0; i < 8; i++) rx_pulse(8'(8'h10 + i));
    apb_read(8'h05, 32'h0800, "rx_level8");
    apb_read(8'h04, 32'h07, "status_rx_full");
    apb_read(8'h01, 32'h10, "rx_read_with_push", 1'b1, 8'hEE);
    apb_read(8'h05, 32'h0800, "rx_level_pushpop");
    apb_read(8'h04, 32'h07, "status_no_overrun");
    rx_pulse(8'h77);
    apb_read(8'h04, 32'h17, "status_overrun");
    for (int i = 1; i < 8; i++) apb_read(8'h01, 32'(8'h10 + i), "rx_drain");
    apb_read(8'h01, 32'hEE, "rx_drain_last");
    apb_read(8'h01, 32'h0, "rx_drain_empty");
    apb_read(8'h04, 32'h14, "status_overrun_sticky");
    expect_out(SEL_IRQ, 1, "irq_overrun");
    apb_write(8'h04, 32'h10);
    apb_read(8'h04, 32'h04, "status_overrun_cleared");
    apb_write(8'h03, 32'h00);
    rx_pulse(8'h42);
    apb_read(8'h05, 32'h0, "rx_ignored_when_disabled");
    apb_write(8'h03, 32'h02);
    rx_pulse(8'h01);
    rx_pulse(8'h02);
    apb_read(8'h05, 32'h0200, "rx_level2");
    apb_write(8'h03, 32'h22);
    apb_read(8'h05, 32'h0, "rx_flushed");
    apb_read(8'h03, 32'h02, "ctrl_rxflush_reads0");

    // 6: asynchronous reset mid-stream
    apb_write(8'h03, 32'h01);
    apb_write(8'h00, 32'h11);
    apb_write(8'h00, 32'h22);
    apb_write(8'h00, 32'h33);
    expect_out(SEL_TXDATA, 32'h11, "pre_reset_head");
    @(posedge pClk); #3;
    pReset = 1'b0;
    expect_out(SEL_TXVALID, 0, "async_rst_txvalid");
    expect_out(SEL_TXDATA, 0, "async_rst_txdata");
    expect_out(SEL_TXEN, 0, "async_rst_txen");
    @(posedge pClk); #1 pReset = 1'b1;
    apb_read(8'h05, 32'h0, "post_rst_level");
    apb_read(8'h04, 32'h04, "post_rst_status");
    apb_read(8'h02, 32'h0, "post_rst_baud");
    expect_out(SEL_IRQ, 0, "post_rst_irq");

`ifdef UART_RX_THRESH_EN
    apb_write(8'h03, 32'h0406);
    apb_read(8'h03, 32'h0406, "ctrl_thresh_rw");
    for (int i = 0; i < 3; i++) rx_pulse(8'(8'hA0 + i));
    @(posedge pClk);
    expect_out(SEL_IRQ, 0, "irq_below_thresh");
    apb_read(8'h04, 32'h05, "status_below_thresh");
    rx_pulse(8'hA3);
    @(posedge pClk);
    expect_out(SEL_IRQ, 1, "irq_at_thresh");
    apb_read(8'h04, 32'h45, "status_at_thresh");
`else
    apb_write(8'h03, 32'h0406);
    apb_read(8'h03, 32'h0006, "ctrl_thresh_ignored");
    rx_pulse(8'hA0);
    @(posedge pClk);
    expect_out(SEL_IRQ, 1, "irq_base_rx");
    apb_read(8'h04, 32'h05, "status_no_thresh_bit");
`endif

    repeat (2) @(posedge pClk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
